// File: rtl/time_set_ctrl.sv
// Button-driven time-setting controller: captures the running time on entry to
// set mode, edits hours then minutes with inc/dec and auto-repeat, and strobes a load on exit.
module time_set_ctrl #(
    parameter int unsigned REPEAT_DELAY  = 25_000_000,
    parameter int unsigned REPEAT_PERIOD = 5_000_000,
    parameter int unsigned TIMEOUT       = 500_000_000
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                btn_mode,
    input  logic                btn_inc,
    input  logic                btn_dec,
    input  logic [$clog2(24):0] hours,
    input  logic [$clog2(60):0] minutes,
    output logic [$clog2(24):0] hours_settings,
    output logic [$clog2(60):0] minutes_settings,
    output logic                settings_signal,
    output logic                field_sel,
    output logic                time_load
);

    localparam int HW = $clog2(24) + 1;
    localparam int MW = $clog2(60) + 1;
    localparam int unsigned HOLD_MAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
    localparam int HCW = $clog2(HOLD_MAX + 1);
    localparam int TCW = $clog2(TIMEOUT + 1);

    localparam logic [HW-1:0]  H_LAST  = HW'(23);
    localparam logic [MW-1:0]  M_LAST  = MW'(59);
    localparam logic [HCW-1:0] DLY     = HCW'(REPEAT_DELAY);
    localparam logic [HCW-1:0] PER     = HCW'(REPEAT_PERIOD);
    localparam logic [TCW-1:0] TO_LAST = TCW'(TIMEOUT - 1);

    typedef enum logic [1:0] {IDLE, SET_HOUR, SET_MIN} state_e;

    state_e         state_q, state_d;
    logic           mode_q, inc_q, dec_q;
    logic [HW-1:0]  hs_q, hs_d;
    logic [MW-1:0]  ms_q, ms_d;
    logic [HCW-1:0] hold_q, hold_d;
    logic           rep_q, rep_d;
    logic [TCW-1:0] to_q, to_d;
    logic           settings_q, settings_d;
    logic           field_q, field_d;
    logic           load_q, load_d;

    logic mode_pr, inc_pr, dec_pr, any_pr;
    logic in_set, one_held, rep_step, press_step, do_step, timeout_hit;
    logic [HCW-1:0] hold_lim;

    assign mode_pr  = btn_mode & ~mode_q;
    assign inc_pr   = btn_inc & ~inc_q;
    assign dec_pr   = btn_dec & ~dec_q;
    assign any_pr   = mode_pr | inc_pr | dec_pr;
    assign in_set   = (state_q != IDLE);
    assign one_held = btn_inc ^ btn_dec;
    // First repeat waits the delay, later ones the period; the counter restarts at 1 after each step.
    assign hold_lim = rep_q ? PER : DLY;

    assign press_step  = in_set & one_held & ~mode_pr & (inc_pr | dec_pr);
    assign rep_step    = in_set & one_held & ~mode_pr & ~(inc_pr | dec_pr)
                         & (hold_q != '0) & (hold_q == hold_lim);
    assign do_step     = press_step | rep_step;
    assign timeout_hit = in_set & ~any_pr & ~rep_step & (to_q == TO_LAST);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:     if (mode_pr) state_d = SET_HOUR;
            SET_HOUR: if (mode_pr) state_d = SET_MIN;
                      else if (timeout_hit) state_d = IDLE;
            SET_MIN:  if (mode_pr || timeout_hit) state_d = IDLE;
            default:  state_d = IDLE;
        endcase
    end

    always_comb begin
        settings_d = (state_d != IDLE);
        field_d    = (state_d == SET_MIN);
        load_d     = (state_q == SET_MIN) & mode_pr;
    end

    always_comb begin
        hs_d = hs_q;
        ms_d = ms_q;
        if (state_q == IDLE && mode_pr) begin
            hs_d = (hours > H_LAST)   ? '0 : hours;
            ms_d = (minutes > M_LAST) ? '0 : minutes;
        end else if (do_step) begin
            if (state_q == SET_HOUR) begin
                if (btn_inc) hs_d = (hs_q == H_LAST) ? '0 : hs_q + 1'b1;
                else         hs_d = (hs_q == '0) ? H_LAST : hs_q - 1'b1;
            end else begin
                if (btn_inc) ms_d = (ms_q == M_LAST) ? '0 : ms_q + 1'b1;
                else         ms_d = (ms_q == '0) ? M_LAST : ms_q - 1'b1;
            end
        end
    end

    // Zero means "not counting": only a fresh press arms the hold counter.
    always_comb begin
        hold_d = '0;
        rep_d  = 1'b0;
        if (in_set && !mode_pr && one_held && !timeout_hit) begin
            if (inc_pr || dec_pr) begin
                hold_d = HCW'(1);
            end else if (hold_q != '0) begin
                if (hold_q == hold_lim) begin
                    hold_d = HCW'(1);
                    rep_d  = 1'b1;
                end else begin
                    hold_d = hold_q + 1'b1;
                    rep_d  = rep_q;
                end
            end
        end
    end

    always_comb begin
        if (state_d == IDLE || state_q == IDLE || any_pr || rep_step) begin
            to_d = '0;
        end else begin
            to_d = to_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mode_q     <= 1'b1;
            inc_q      <= 1'b1;
            dec_q      <= 1'b1;
            hs_q       <= '0;
            ms_q       <= '0;
            hold_q     <= '0;
            rep_q      <= 1'b0;
            to_q       <= '0;
            settings_q <= 1'b0;
            field_q    <= 1'b0;
            load_q     <= 1'b0;
        end else begin
            mode_q     <= btn_mode;
            inc_q      <= btn_inc;
            dec_q      <= btn_dec;
            hs_q       <= hs_d;
            ms_q       <= ms_d;
            hold_q     <= hold_d;
            rep_q      <= rep_d;
            to_q       <= to_d;
            settings_q <= settings_d;
            field_q    <= field_d;
            load_q     <= load_d;
        end
    end

    assign hours_settings   = hs_q;
    assign minutes_settings = ms_q;
    assign settings_signal  = settings_q;
    assign field_sel        = field_q;
    assign time_load        = load_q;

endmodule

// File: tb/tb_time_set_ctrl.sv
// Bench for time_set_ctrl: directed scenarios with constant expectations, then
// random button traffic checked against a cycle-level behavioural model.
module tb_time_set_ctrl;

    localparam int RD = 8;
    localparam int RP = 4;
    localparam int TO = 32;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       btn_mode, btn_inc, btn_dec;
    logic [5:0] hours;
    logic [6:0] minutes;
    logic [5:0] hours_settings;
    logic [6:0] minutes_settings;
    logic       settings_signal, field_sel, time_load;

    int total = 0;
    int bad   = 0;
    int tl_cnt = 0;

    time_set_ctrl #(.REPEAT_DELAY(RD), .REPEAT_PERIOD(RP), .TIMEOUT(TO)) dut (
        .clk(clk), .rst_n(rst_n),
        .btn_mode(btn_mode), .btn_inc(btn_inc), .btn_dec(btn_dec),
        .hours(hours), .minutes(minutes),
        .hours_settings(hours_settings), .minutes_settings(minutes_settings),
        .settings_signal(settings_signal), .field_sel(field_sel), .time_load(time_load)
    );

    always #5 clk = ~clk;

    always @(negedge clk) if (time_load === 1'b1) tl_cnt <= tl_cnt + 1;

    // Behavioural model: st 0=idle 1=hours 2=minutes; held = edges since the
    // press of the single held button (-1 when not tracking); idle = edges without activity.
    typedef struct {
        int st; int h; int m; bit load;
        bit pm; bit pi; bit pd;
        int held; int idle;
    } mdl_t;

    mdl_t mdl;

    function automatic mdl_t mdl_reset();
        mdl_t r;
        r.st = 0; r.h = 0; r.m = 0; r.load = 0;
        r.pm = 1; r.pi = 1; r.pd = 1;
        r.held = -1; r.idle = 0;
        return r;
    endfunction

    function automatic mdl_t model_step(mdl_t s, bit mode, bit inc, bit dec, int hr, int mn);
        mdl_t n = s;
        bit pm = mode && !s.pm;
        bit pi = inc && !s.pi;
        bit pd = dec && !s.pd;
        bit act, step;
        n.pm = mode; n.pi = inc; n.pd = dec; n.load = 0;
        if (s.st == 0) begin
            if (pm) begin
                n.st = 1; n.h = (hr > 23) ? 0 : hr; n.m = (mn > 59) ? 0 : mn;
                n.idle = 0; n.held = -1;
            end
        end else begin
            act = pm || pi || pd;
            step = 0;
            if (pm) begin
                n.load = (s.st == 2);
                n.st = (s.st == 1) ? 2 : 0;
                n.held = -1;
            end else if (inc != dec) begin
                if (pi || pd) n.held = 0;
                else if (s.held >= 0) n.held = s.held + 1;
                step = (n.held == 0) || (n.held >= RD && (n.held - RD) % RP == 0);
                if (step) begin
                    if (s.st == 1) n.h = inc ? (s.h + 1) % 24 : (s.h + 23) % 24;
                    else           n.m = inc ? (s.m + 1) % 60 : (s.m + 59) % 60;
                end
            end else begin
                n.held = -1;
            end
            if (act || step) n.idle = 0;
            else begin
                n.idle = s.idle + 1;
                if (n.idle >= TO) begin n.st = 0; n.held = -1; end
            end
        end
        return n;
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) mdl <= mdl_reset();
        else        mdl <= model_step(mdl, btn_mode, btn_inc, btn_dec, int'(hours), int'(minutes));
    end

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic test_reset();
        rst_n = 1'b1; btn_mode = 0; btn_inc = 0; btn_dec = 0; hours = 0; minutes = 0;
        #2 rst_n = 1'b0;
        #1;
        total++;
        if ({hours_settings, minutes_settings, settings_signal, field_sel, time_load} !== 16'h0) begin
            bad++; $display("FAIL reset_async got=%h want=0", {hours_settings, minutes_settings, settings_signal, field_sel, time_load});
        end
        tick(2);
        rst_n = 1'b1;
        tick(2);
        total++;
        if ({hours_settings, minutes_settings, settings_signal, field_sel, time_load} !== 16'h0) begin
            bad++; $display("FAIL reset_release got=%h want=0", {hours_settings, minutes_settings, settings_signal, field_sel, time_load});
        end
    endtask

    task automatic test_commit();
        hours = 13; minutes = 45;
        btn_mode = 1; tick(1);
        total++;
        if ({settings_signal, field_sel, hours_settings, minutes_settings} !== {1'b1, 1'b0, 6'd13, 7'd45}) begin
            bad++; $display("FAIL commit_capture got=%0d:%0d ss=%b fs=%b want=13:45 ss=1 fs=0",
                            hours_settings, minutes_settings, settings_signal, field_sel);
        end
        btn_mode = 0; tick(1);
        repeat (2) begin btn_inc = 1; tick(1); btn_inc = 0; tick(1); end
        total++;
        if ({hours_settings, minutes_settings} !== {6'd15, 7'd45}) begin
            bad++; $display("FAIL commit_inc got=%0d:%0d want=15:45", hours_settings, minutes_settings);
        end
        btn_mode = 1; tick(1); btn_mode = 0; tick(1);
        btn_dec = 1; tick(1); btn_dec = 0; tick(1);
        total++;
        if ({field_sel, hours_settings, minutes_settings} !== {1'b1, 6'd15, 7'd44}) begin
            bad++; $display("FAIL commit_dec got=%0d:%0d fs=%b want=15:44 fs=1", hours_settings, minutes_settings, field_sel);
        end
        btn_mode = 1; tick(1);
        total++;
        if ({time_load, settings_signal, hours_settings, minutes_settings} !== {1'b1, 1'b0, 6'd15, 7'd44}) begin
            bad++; $display("FAIL commit_load got tl=%b ss=%b %0d:%0d want tl=1 ss=0 15:44",
                            time_load, settings_signal, hours_settings, minutes_settings);
        end
        btn_mode = 0; tick(1);
        total++;
        if (time_load !== 1'b0) begin
            bad++; $display("FAIL commit_pulse_width got tl=%b want 0", time_load);
        end
    endtask

    task automatic test_wrap();
        hours = 23; minutes = 59;
        btn_mode = 1; tick(1); btn_mode = 0; tick(1);
        btn_inc = 1; tick(1); btn_inc = 0;
        total++;
        if (hours_settings !== 6'd0) begin bad++; $display("FAIL wrap_h_inc got=%0d want=0", hours_settings); end
        tick(1);
        btn_dec = 1; tick(1); btn_dec = 0;
        total++;
        if (hours_settings !== 6'd23) begin bad++; $display("FAIL wrap_h_dec got=%0d want=23", hours_settings); end
        tick(1);
        btn_mode = 1; tick(1); btn_mode = 0; tick(1);
        btn_inc = 1; tick(1); btn_inc = 0;
        total++;
        if (minutes_settings !== 7'd0) begin bad++; $display("FAIL wrap_m_inc got=%0d want=0", minutes_settings); end
        tick(1);
        btn_dec = 1; tick(1); btn_dec = 0;
        total++;
        if (minutes_settings !== 7'd59) begin bad++; $display("FAIL wrap_m_dec got=%0d want=59", minutes_settings); end
        tick(1);
        btn_mode = 1; tick(1); btn_mode = 0; tick(1);
    endtask

    task automatic test_repeat();
        int exp;
        int errs = 0;
        hours = 5; minutes = 10;
        btn_mode = 1; tick(1); btn_mode = 0; tick(1);
        btn_mode = 1; tick(1); btn_mode = 0; tick(1);
        btn_inc = 1;
        for (int j = 0; j <= 20; j++) begin
            tick(1);
            exp = 11 + int'(j >= RD) + int'(j >= RD + RP) + int'(j >= RD + 2*RP) + int'(j >= RD + 3*RP);
            total++;
            if (minutes_settings !== 7'(exp)) begin
                bad++; errs++;
                if (errs < 5) $display("FAIL repeat_step press+%0d got=%0d want=%0d", j, minutes_settings, exp);
            end
        end
        btn_inc = 0; tick(10);
        total++;
        if (minutes_settings !== 7'd15) begin bad++; $display("FAIL repeat_release got=%0d want=15", minutes_settings); end
        btn_mode = 1; tick(1); btn_mode = 0; tick(1);
    endtask

    task automatic test_timeout();
        int tl0 = tl_cnt;
        hours = 7; minutes = 8;
        btn_mode = 1; tick(1); btn_mode = 0;
        tick(31);
        total++;
        if (settings_signal !== 1'b1) begin bad++; $display("FAIL timeout_early got ss=%b want 1 at entry+31", settings_signal); end
        tick(1);
        total++;
        if ({settings_signal, field_sel} !== 2'b00) begin bad++; $display("FAIL timeout_exit got ss=%b fs=%b want 0 0", settings_signal, field_sel); end
        btn_mode = 1; tick(1); btn_mode = 0;
        tick(19);
        btn_inc = 1; tick(1); btn_inc = 0;
        total++;
        if (hours_settings !== 6'd8) begin bad++; $display("FAIL timeout_inc got=%0d want=8", hours_settings); end
        tick(31);
        total++;
        if (settings_signal !== 1'b1) begin bad++; $display("FAIL timeout_extend got ss=%b want 1 at press+31", settings_signal); end
        tick(1);
        total++;
        if ({settings_signal, hours_settings} !== {1'b0, 6'd8}) begin
            bad++; $display("FAIL timeout_extend_exit got ss=%b h=%0d want ss=0 h=8", settings_signal, hours_settings);
        end
        total++;
        if (tl_cnt !== tl0) begin bad++; $display("FAIL timeout_no_load got loads=%0d want=%0d", tl_cnt, tl0); end
    endtask

    task automatic test_conflict();
        int tl0;
        hours = 9; minutes = 20;
        btn_mode = 1; tick(1); btn_mode = 0; tick(1);
        btn_inc = 1; btn_dec = 1; tick(1);
        total++;
        if (hours_settings !== 6'd9) begin bad++; $display("FAIL conflict_incdec got=%0d want=9", hours_settings); end
        tick(12);
        total++;
        if (hours_settings !== 6'd9) begin bad++; $display("FAIL conflict_incdec_held got=%0d want=9", hours_settings); end
        btn_inc = 0; btn_dec = 0; tick(1);
        btn_mode = 1; btn_inc = 1; tick(1);
        total++;
        if ({field_sel, hours_settings} !== {1'b1, 6'd9}) begin
            bad++; $display("FAIL conflict_mode_inc got fs=%b h=%0d want fs=1 h=9", field_sel, hours_settings);
        end
        btn_mode = 0; btn_inc = 0; tick(1);
        tl0 = tl_cnt;
        #2 rst_n = 1'b0;
        #1;
        total++;
        if ({hours_settings, minutes_settings, settings_signal, field_sel, time_load} !== 16'h0) begin
            bad++; $display("FAIL midedit_reset got=%h want=0", {hours_settings, minutes_settings, settings_signal, field_sel, time_load});
        end
        btn_mode = 1;
        tick(2);
        rst_n = 1'b1;
        tick(3);
        total++;
        if ({settings_signal, tl_cnt == tl0} !== 2'b01) begin
            bad++; $display("FAIL held_mode_reset got ss=%b loads=%0d want ss=0 loads=%0d", settings_signal, tl_cnt, tl0);
        end
        btn_mode = 0; tick(1);
    endtask

    task automatic test_oor();
        hours = 30; minutes = 63;
        btn_mode = 1; tick(1);
        total++;
        if ({settings_signal, hours_settings, minutes_settings} !== {1'b1, 6'd0, 7'd0}) begin
            bad++; $display("FAIL oor_capture got ss=%b %0d:%0d want ss=1 0:00", settings_signal, hours_settings, minutes_settings);
        end
        btn_mode = 0; tick(1);
        btn_mode = 1; tick(1); btn_mode = 0; tick(1);
        btn_mode = 1; tick(1); btn_mode = 0; tick(1);
    endtask

    task automatic test_random();
        logic [15:0] got, exp;
        int errs = 0;
        for (int c = 0; c < 1500; c++) begin
            if ($urandom_range(0, 24) == 0) btn_mode = ~btn_mode;
            if ($urandom_range(0, 11) == 0) btn_inc  = ~btn_inc;
            if ($urandom_range(0, 11) == 0) btn_dec  = ~btn_dec;
            if ($urandom_range(0, 7) == 0) begin
                hours   = 6'($urandom_range(0, 31));
                minutes = 7'($urandom_range(0, 63));
            end
            tick(1);
            got = {hours_settings, minutes_settings, settings_signal, field_sel, time_load};
            exp = {6'(mdl.h), 7'(mdl.m), mdl.st != 0, mdl.st == 2, mdl.load};
            total++;
            if (got !== exp) begin
                bad++; errs++;
                if (errs < 8) $display("FAIL random_cycle %0d got=%h want=%h", c, got, exp);
            end
        end
        btn_mode = 0; btn_inc = 0; btn_dec = 0;
        tick(2);
    endtask

    initial begin
        test_reset();
        test_commit();
        test_wrap();
        test_repeat();
        test_timeout();
        test_conflict();
        test_oor();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
